sdr_init_seq: RTL and testbench
===============================

SDR_INIT_SEQ -- requirements
Module: sdr_init_seq

Interface
REQ-001 SHALL have parameter CLK_MHZ, default 166, clock frequency in MHz.
REQ-002 SHALL have parameter T_PWR_US, default 100, power-up NOP wait in microseconds; PWR_CYC = CLK_MHZ*T_PWR_US.
REQ-003 SHALL have parameters T_RP=3, T_RFC=10, T_MRD=2, each a command-to-next-command gap in clocks, each at least 1.
REQ-004 SHALL have parameter N_AREF, default 2, number of AUTO REFRESH commands, range 1..15.
REQ-005 SHALL have parameters ROW_W=13, BA_W=2, DQM_W=2, the address, bank and byte-mask widths.
REQ-006 SHALL have parameter EMRS_EN, default 0; when 1, an EXTENDED MODE REGISTER SET follows LMR.
REQ-007 SHALL have parameter AUTO_START, default 1; when 1, the sequence starts on the first cycle after reset.
REQ-008 Ports: clk  input  1  sole clock, rising-edge.
REQ-009 Ports: rst  input  1  synchronous, active-high reset.
REQ-010 Ports: init_req  input  1  one-cycle start or re-init pulse.
REQ-011 Ports: mode_reg  input  ROW_W  LMR value, sampled when the start is accepted.
REQ-012 Ports: ext_mode_reg  input  ROW_W  EMRS value, sampled when the start is accepted.
REQ-013 Ports: init_busy  output  1  high while the sequence runs.
REQ-014 Ports: init_done  output  1  level, high once the sequence completes.
REQ-015 Ports: sdr_CKE, sdr_nCS, sdr_nRAS, sdr_nCAS, sdr_nWE  output  1 each  SDRAM control.
REQ-016 Ports: sdr_BA  output  BA_W  bank address.
REQ-017 Ports: sdr_A  output  ROW_W  address.
REQ-018 Ports: sdr_DQM  output  DQM_W  byte mask.

Function
REQ-019 All outputs SHALL be registered; commands are {nCS,nRAS,nCAS,nWE}: NOP 0111, PRE 0010, AREF 0001, LMR/EMRS 0000.
REQ-020 States SHALL be IDLE, PWR_WAIT, PRE, AREF, MRS, EMRS, DONE; every command is driven for exactly one cycle and NOP on all other cycles.
REQ-021 The start SHALL be accepted from IDLE on AUTO_START (first cycle after reset) or on init_req; mode_reg and ext_mode_reg are latched on that cycle.
REQ-022 A cold start SHALL raise sdr_CKE and init_busy on the cycle after acceptance, then hold NOP for PWR_CYC cycles.
REQ-023 PRE SHALL appear PWR_CYC cycles after sdr_CKE rises, with A[10]=1 and all other A and BA bits 0.
REQ-024 AREF #1 SHALL appear T_RP cycles after PRE; AREF #k+1 SHALL appear T_RFC cycles after AREF #k.
REQ-025 LMR SHALL appear T_RFC cycles after the last AREF, with A = latched mode_reg and BA = 0.
REQ-026 If EMRS_EN=1, EMRS SHALL appear T_MRD cycles after LMR, with A = latched ext_mode_reg and BA = 2'b10 (upper BA bits 0).
REQ-027 init_done SHALL rise and init_busy SHALL fall T_MRD cycles after the final mode command; the state then moves to DONE.
REQ-028 In DONE, an init_req SHALL start a re-init: init_done falls the next cycle, PWR_WAIT is skipped, and PRE appears on the cycle after acceptance.
REQ-029 init_req SHALL be ignored while init_busy=1.
REQ-030 Any init_req when AUTO_START=0 and in IDLE SHALL start a cold sequence.
REQ-031 A single down-counter of width clog2(max(PWR_CYC,T_RFC)+1) SHALL time every gap, with no wrap-around.
REQ-032 An AREF counter of 4 bits SHALL count N_AREF.
REQ-033 sdr_DQM SHALL be all-ones while init_done=0 and all-zeros once init_done=1.
REQ-034 sdr_nCS SHALL be 0 except in reset.

Reset
REQ-035 rst=1 SHALL synchronously force: state IDLE, counters 0, sdr_CKE=0, command 1111 (deselect), sdr_A=0, sdr_BA=0, sdr_DQM all-ones, init_busy=0, init_done=0.
REQ-036 rst asserted mid-sequence SHALL abort on the next edge; the next start is a cold start.

Structure
REQ-037 Command encodings, state encoding and the cycle computation function SHALL reside in shared package sdr_pkg.
REQ-038 The module SHALL have no sub-modules.

Verification
REQ-039 Use CLK_MHZ=10, T_PWR_US=2, T_RP=3, T_RFC=7, T_MRD=2, N_AREF=2, EMRS_EN=0. Release reset with CKE rising at t -> PRE at t+20 with A=0x400, AREF at t+23 and t+30, LMR at t+37 with A=0x032, init_done rising at t+39.
REQ-040 Same parameters with EMRS_EN=1 and ext_mode_reg=0x020 -> EMRS at t+39 with BA=2, init_done rising at t+41.
REQ-041 Pulse init_req in DONE at cycle u -> init_done=0 at u+1, PRE at u+1, LMR at u+18, CKE stays 1, no power-up wait.
REQ-042 Pulse init_req at t+25 mid-sequence -> timing identical to REQ-039.
REQ-043 Assert rst at t+28 -> next edge CKE=0, command 1111; after release, full cold sequence repeats.
REQ-044 With N_AREF=8, exactly 8 AREF commands SHALL appear, 7 cycles apart, and every non-command cycle SHALL be NOP.

Source files
------------

// File: rtl/sdr_pkg.sv
// sdr_pkg -- shared definitions for the SDRAM power-up initialisation sequencer.
//   Command encodings for {nCS,nRAS,nCAS,nWE}, the sequencer state type and the
//   helper functions that turn timing parameters into cycle counts and widths.
package sdr_pkg;

   localparam logic [3:0] CMD_DESL = 4'b1111;  // deselect, only driven in reset
   localparam logic [3:0] CMD_NOP  = 4'b0111;
   localparam logic [3:0] CMD_PRE  = 4'b0010;
   localparam logic [3:0] CMD_AREF = 4'b0001;
   localparam logic [3:0] CMD_MRS  = 4'b0000;  // LMR and EMRS share the encoding

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PWR_WAIT,
      ST_PRE,
      ST_AREF,
      ST_MRS,
      ST_EMRS,
      ST_DONE
   } state_t;

   // Power-up wait in clocks.
   function automatic int pwr_cycles(input int mhz, input int us);
      return mhz * us;
   endfunction

   // Gap counter width: the longest gap is either the power-up wait or tRFC.
   // tRP and tMRD are expected to be no longer than tRFC.
   function automatic int cnt_width(input int pwr, input int rfc);
      int m;
      m = (pwr > rfc) ? pwr : rfc;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/sdr_init_seq.sv
// sdr_init_seq -- SDRAM initialisation sequencer.
//   Cold start: CKE high, NOP for the power-up wait, PRECHARGE ALL, N_AREF x
//   AUTO REFRESH, LOAD MODE REGISTER, optional EXTENDED MODE REGISTER SET, then
//   init_done. A re-init from DONE skips the power-up wait and starts at PRE.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   init_req             one-cycle start / re-init pulse (ignored while busy)
//   mode_reg             LMR value, latched when a start is accepted
//   ext_mode_reg         EMRS value, latched when a start is accepted
//   init_busy            high while the sequence runs
//   init_done            level, high once the sequence has completed
//   sdr_CKE .. sdr_DQM   registered SDRAM control, bank, address and byte mask
module sdr_init_seq
   import sdr_pkg::*;
#(
   parameter int CLK_MHZ    = 166,
   parameter int T_PWR_US   = 100,
   parameter int T_RP       = 3,
   parameter int T_RFC      = 10,
   parameter int T_MRD      = 2,
   parameter int N_AREF     = 2,
   parameter int ROW_W      = 13,
   parameter int BA_W       = 2,
   parameter int DQM_W      = 2,
   parameter int EMRS_EN    = 0,
   parameter int AUTO_START = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             init_req,
   input  logic [ROW_W-1:0] mode_reg,
   input  logic [ROW_W-1:0] ext_mode_reg,
   output logic             init_busy,
   output logic             init_done,
   output logic             sdr_CKE,
   output logic             sdr_nCS,
   output logic             sdr_nRAS,
   output logic             sdr_nCAS,
   output logic             sdr_nWE,
   output logic [BA_W-1:0]  sdr_BA,
   output logic [ROW_W-1:0] sdr_A,
   output logic [DQM_W-1:0] sdr_DQM
);

   localparam int PWR_CYC = pwr_cycles(CLK_MHZ, T_PWR_US);
   localparam int CW      = cnt_width(PWR_CYC, T_RFC);

   // PRECHARGE ALL is selected by A[10].
   localparam logic [ROW_W-1:0] A_PALL = ROW_W'(1) << 10;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [3:0]       aref_cnt;
   logic             auto_pend;   // AUTO_START still owed since last reset
   logic [ROW_W-1:0] mode_q;
   logic [ROW_W-1:0] ext_q;
   logic [3:0]       cmd;

   assign {sdr_nCS, sdr_nRAS, sdr_nCAS, sdr_nWE} = cmd;

   // Gaps are loaded as (gap-1) on the command edge: the next command is issued
   // on the edge that finds the counter at zero, exactly gap cycles later.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         aref_cnt  <= '0;
         auto_pend <= (AUTO_START != 0);
         mode_q    <= '0;
         ext_q     <= '0;
         cmd       <= CMD_DESL;
         sdr_CKE   <= 1'b0;
         sdr_A     <= '0;
         sdr_BA    <= '0;
         sdr_DQM   <= '1;
         init_busy <= 1'b0;
         init_done <= 1'b0;
      end else begin
         cmd    <= CMD_NOP;
         sdr_A  <= '0;
         sdr_BA <= '0;
         if (cnt != '0) cnt <= cnt - CW'(1);

         case (state)
            ST_IDLE: begin
               if (auto_pend || init_req) begin
                  auto_pend <= 1'b0;
                  mode_q    <= mode_reg;
                  ext_q     <= ext_mode_reg;
                  sdr_CKE   <= 1'b1;
                  init_busy <= 1'b1;
                  cnt       <= CW'(PWR_CYC - 1);
                  state     <= ST_PWR_WAIT;
               end
            end
            ST_PWR_WAIT: begin
               if (cnt == '0) begin
                  cmd   <= CMD_PRE;
                  sdr_A <= A_PALL;
                  cnt   <= CW'(T_RP - 1);
                  state <= ST_PRE;
               end
            end
            ST_PRE: begin
               if (cnt == '0) begin
                  cmd      <= CMD_AREF;
                  aref_cnt <= 4'd1;
                  cnt      <= CW'(T_RFC - 1);
                  state    <= ST_AREF;
               end
            end
            ST_AREF: begin
               if (cnt == '0) begin
                  if (aref_cnt < 4'(N_AREF)) begin
                     cmd      <= CMD_AREF;
                     aref_cnt <= aref_cnt + 4'd1;
                     cnt      <= CW'(T_RFC - 1);
                  end else begin
                     cmd   <= CMD_MRS;
                     sdr_A <= mode_q;
                     cnt   <= CW'(T_MRD - 1);
                     state <= ST_MRS;
                  end
               end
            end
            ST_MRS: begin
               if (cnt == '0) begin
                  if (EMRS_EN != 0) begin
                     cmd    <= CMD_MRS;
                     sdr_A  <= ext_q;
                     sdr_BA <= BA_W'(2);
                     cnt    <= CW'(T_MRD - 1);
                     state  <= ST_EMRS;
                  end else begin
                     init_done <= 1'b1;
                     init_busy <= 1'b0;
                     sdr_DQM   <= '0;
                     aref_cnt  <= '0;
                     state     <= ST_DONE;
                  end
               end
            end
            ST_EMRS: begin
               if (cnt == '0) begin
                  init_done <= 1'b1;
                  init_busy <= 1'b0;
                  sdr_DQM   <= '0;
                  aref_cnt  <= '0;
                  state     <= ST_DONE;
               end
            end
            ST_DONE: begin
               // Re-init: the device is already powered, go straight to PRE.
               if (init_req) begin
                  mode_q    <= mode_reg;
                  ext_q     <= ext_mode_reg;
                  init_done <= 1'b0;
                  init_busy <= 1'b1;
                  sdr_DQM   <= '1;
                  cmd       <= CMD_PRE;
                  sdr_A     <= A_PALL;
                  cnt       <= CW'(T_RP - 1);
                  state     <= ST_PRE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sdr_init_seq.sv
// tb_sdr_init_seq -- four sequencer instances (plain, EMRS, 8 refreshes,
// manual start) driven with shared directed and random stimulus and checked
// every cycle against a schedule-based model, plus literal timing pins.
module tb_sdr_init_seq;

   localparam int CLK_MHZ = 10, T_PWR_US = 2, T_RP = 3, T_RFC = 7, T_MRD = 2;
   localparam int PWR = CLK_MHZ * T_PWR_US;
   localparam int ND  = 4;
   localparam int OW  = 24;

   logic clk = 1'b0, rst = 1'b1, init_req = 1'b0;
   logic [12:0] mode_reg = 13'h032, ext_mode_reg = 13'h020;
   logic [ND-1:0] cke, ncs, nras, ncas, nwe, busy, done;
   logic [1:0]  ba  [ND];
   logic [12:0] a   [ND];
   logic [1:0]  dqm [ND];

   int n_chk = 0, n_fail = 0, cyc = 0;

   always #5 clk = ~clk;

   sdr_init_seq #(.CLK_MHZ(CLK_MHZ), .T_PWR_US(T_PWR_US), .T_RP(T_RP), .T_RFC(T_RFC),
      .T_MRD(T_MRD), .N_AREF(2), .EMRS_EN(0), .AUTO_START(1)) dut0 (
      .clk(clk), .rst(rst), .init_req(init_req), .mode_reg(mode_reg), .ext_mode_reg(ext_mode_reg),
      .init_busy(busy[0]), .init_done(done[0]), .sdr_CKE(cke[0]), .sdr_nCS(ncs[0]),
      .sdr_nRAS(nras[0]), .sdr_nCAS(ncas[0]), .sdr_nWE(nwe[0]), .sdr_BA(ba[0]), .sdr_A(a[0]),
      .sdr_DQM(dqm[0]));
   sdr_init_seq #(.CLK_MHZ(CLK_MHZ), .T_PWR_US(T_PWR_US), .T_RP(T_RP), .T_RFC(T_RFC),
      .T_MRD(T_MRD), .N_AREF(2), .EMRS_EN(1), .AUTO_START(1)) dut1 (
      .clk(clk), .rst(rst), .init_req(init_req), .mode_reg(mode_reg), .ext_mode_reg(ext_mode_reg),
      .init_busy(busy[1]), .init_done(done[1]), .sdr_CKE(cke[1]), .sdr_nCS(ncs[1]),
      .sdr_nRAS(nras[1]), .sdr_nCAS(ncas[1]), .sdr_nWE(nwe[1]), .sdr_BA(ba[1]), .sdr_A(a[1]),
      .sdr_DQM(dqm[1]));
   sdr_init_seq #(.CLK_MHZ(CLK_MHZ), .T_PWR_US(T_PWR_US), .T_RP(T_RP), .T_RFC(T_RFC),
      .T_MRD(T_MRD), .N_AREF(8), .EMRS_EN(0), .AUTO_START(1)) dut2 (
      .clk(clk), .rst(rst), .init_req(init_req), .mode_reg(mode_reg), .ext_mode_reg(ext_mode_reg),
      .init_busy(busy[2]), .init_done(done[2]), .sdr_CKE(cke[2]), .sdr_nCS(ncs[2]),
      .sdr_nRAS(nras[2]), .sdr_nCAS(ncas[2]), .sdr_nWE(nwe[2]), .sdr_BA(ba[2]), .sdr_A(a[2]),
      .sdr_DQM(dqm[2]));
   sdr_init_seq #(.CLK_MHZ(CLK_MHZ), .T_PWR_US(T_PWR_US), .T_RP(T_RP), .T_RFC(T_RFC),
      .T_MRD(T_MRD), .N_AREF(2), .EMRS_EN(0), .AUTO_START(0)) dut3 (
      .clk(clk), .rst(rst), .init_req(init_req), .mode_reg(mode_reg), .ext_mode_reg(ext_mode_reg),
      .init_busy(busy[3]), .init_done(done[3]), .sdr_CKE(cke[3]), .sdr_nCS(ncs[3]),
      .sdr_nRAS(nras[3]), .sdr_nCAS(ncas[3]), .sdr_nWE(nwe[3]), .sdr_BA(ba[3]), .sdr_A(a[3]),
      .sdr_DQM(dqm[3]));

   // ---------------- model: each start becomes a list of absolute command cycles
   int p_emrs  [ND] = '{0, 1, 0, 0};
   int p_naref [ND] = '{2, 2, 8, 2};
   int p_auto  [ND] = '{1, 1, 1, 0};

   bit m_act[ND], m_idle[ND], m_pend[ND], m_cke[ND], m_busy[ND], m_done[ND];
   int m_pre[ND], m_lmr[ND], m_emrs[ND], m_donec[ND];
   logic [12:0] m_mode[ND], m_ext[ND];
   logic [OW-1:0] exp_v[ND];

   task automatic sched(input int k, input int pre_at);
      m_act[k]   = 1'b1;
      m_mode[k]  = mode_reg;
      m_ext[k]   = ext_mode_reg;
      m_pre[k]   = pre_at;
      m_lmr[k]   = pre_at + T_RP + p_naref[k] * T_RFC;
      m_emrs[k]  = m_lmr[k] + T_MRD;
      m_donec[k] = (p_emrs[k] != 0 ? m_emrs[k] : m_lmr[k]) + T_MRD;
   endtask

   function automatic logic [OW-1:0] got_v(input int k);
      return {cke[k], ncs[k], nras[k], ncas[k], nwe[k], ba[k], a[k], dqm[k], busy[k], done[k]};
   endfunction

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         for (int k = 0; k < ND; k++) begin
            logic [3:0] e_cmd;
            logic [12:0] e_a;
            logic [1:0] e_ba;
            int d;
            e_cmd = 4'b0111; e_a = '0; e_ba = '0;
            if (rst) begin
               m_act[k] = 0; m_idle[k] = 1; m_pend[k] = (p_auto[k] != 0);
               m_cke[k] = 0; m_busy[k] = 0; m_done[k] = 0;
               e_cmd = 4'b1111;
            end else begin
               if (m_idle[k] && (m_pend[k] || init_req)) begin
                  m_idle[k] = 0; m_pend[k] = 0; m_cke[k] = 1; m_busy[k] = 1;
                  sched(k, cyc + PWR);
               end else if (m_done[k] && init_req) begin
                  m_done[k] = 0; m_busy[k] = 1;
                  sched(k, cyc);
               end
               if (m_act[k]) begin
                  d = cyc - m_pre[k] - T_RP;
                  if (cyc == m_pre[k]) begin
                     e_cmd = 4'b0010; e_a = 13'h400;
                  end else if (d >= 0 && (d % T_RFC) == 0 && (d / T_RFC) < p_naref[k]) begin
                     e_cmd = 4'b0001;
                  end else if (cyc == m_lmr[k]) begin
                     e_cmd = 4'b0000; e_a = m_mode[k];
                  end else if (p_emrs[k] != 0 && cyc == m_emrs[k]) begin
                     e_cmd = 4'b0000; e_a = m_ext[k]; e_ba = 2'b10;
                  end
                  if (cyc == m_donec[k]) begin
                     m_done[k] = 1; m_busy[k] = 0; m_act[k] = 0;
                  end
               end
            end
            exp_v[k] = {m_cke[k], e_cmd, e_ba, e_a, (m_done[k] ? 2'b00 : 2'b11), m_busy[k], m_done[k]};
         end
         #2;
         for (int k = 0; k < ND; k++) begin
            n_chk++;
            if (got_v(k) !== exp_v[k]) begin
               n_fail++;
               $display("FAIL outputs dut%0d cyc=%0d got=%h exp=%h", k, cyc, got_v(k), exp_v[k]);
            end
         end
      end
   end

   // ---------------- literal pins
   task automatic check(input string nm, input int got, input int expv);
      n_chk++;
      if (got !== expv) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", nm, got, expv);
      end
   endtask

   function automatic logic [3:0] cmd_of(input int k);
      return {ncs[k], nras[k], ncas[k], nwe[k]};
   endfunction

   task automatic run_cold(input int req_off, input int rst_off);
      int pre0, lmr0, done0, nar0, a_lmr, mrs1, emrs1, a_emrs, ba_emrs, done1, nar2, last2, gap_bad2;
      int ar0[2];
      pre0 = -1; lmr0 = -1; done0 = -1; nar0 = 0; a_lmr = -1; mrs1 = 0; emrs1 = -1;
      a_emrs = -1; ba_emrs = -1; done1 = -1; nar2 = 0; last2 = -1; gap_bad2 = 0;
      ar0[0] = -1; ar0[1] = -1;
      rst = 1'b1; init_req = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_cke", int'(cke[0]), 0);
      check("rst_cmd", int'(cmd_of(0)), 15);
      check("rst_dqm_busy_done_a", int'({dqm[0], busy[0], done[0], a[0]}), 3 << 15);
      rst = 1'b0;
      @(posedge clk); #1;
      check("cke_rise", int'(cke[0]), 1);
      for (int k = 1; k <= 100; k++) begin
         @(posedge clk); #1;
         if (rst_off >= 0 && k == rst_off + 1) begin
            check("abort_cke", int'(cke[0]), 0);
            check("abort_cmd", int'(cmd_of(0)), 15);
            return;
         end
         if (cmd_of(0) == 4'b0010 && pre0 < 0) pre0 = k;
         if (cmd_of(0) == 4'b0001) begin
            if (nar0 < 2) ar0[nar0] = k;
            nar0++;
         end
         if (cmd_of(0) == 4'b0000) begin lmr0 = k; a_lmr = int'(a[0]); end
         if (done[0] && done0 < 0) done0 = k;
         if (cmd_of(1) == 4'b0000) begin
            mrs1++;
            if (mrs1 == 2) begin emrs1 = k; a_emrs = int'(a[1]); ba_emrs = int'(ba[1]); end
         end
         if (done[1] && done1 < 0) done1 = k;
         if (cmd_of(2) == 4'b0001) begin
            if (last2 >= 0 && k - last2 != 7) gap_bad2++;
            last2 = k;
            nar2++;
         end
         init_req = (k == req_off);
         if (k == rst_off) rst = 1'b1;
      end
      init_req = 1'b0;
      check("pre_at", pre0, 20);
      check("aref1_at", ar0[0], 23);
      check("aref2_at", ar0[1], 30);
      check("aref_count", nar0, 2);
      check("lmr_at", lmr0, 37);
      check("lmr_a", a_lmr, 'h032);
      check("done_at", done0, 39);
      check("emrs_at", emrs1, 39);
      check("emrs_a", a_emrs, 'h020);
      check("emrs_ba", ba_emrs, 2);
      check("emrs_done_at", done1, 41);
      check("aref8_count", nar2, 8);
      check("aref8_gaps", gap_bad2, 0);
   endtask

   task automatic run_warm();
      int lmr0, cke_drop;
      lmr0 = -1; cke_drop = 0;
      @(posedge clk); #1;
      init_req = 1'b1;
      @(posedge clk); #1;
      init_req = 1'b0;
      check("warm_done_low", int'(done[0]), 0);
      check("warm_pre_now", int'(cmd_of(0)), 2);
      for (int k = 1; k <= 30; k++) begin
         @(posedge clk); #1;
         if (!cke[0]) cke_drop++;
         if (cmd_of(0) == 4'b0000 && lmr0 < 0) lmr0 = k;
      end
      check("warm_lmr_at", lmr0, 17);
      check("warm_cke_held", cke_drop, 0);
   endtask

   initial begin
      run_cold(-1, -1);
      run_warm();
      run_cold(25, -1);
      run_cold(-1, 28);
      run_cold(-1, -1);
      for (int i = 0; i < 4000; i++) begin
         @(posedge clk); #1;
         mode_reg     = 13'($urandom);
         ext_mode_reg = 13'($urandom);
         init_req     = ($urandom_range(0, 39) == 0);
         if (rst) rst = ($urandom_range(0, 1) == 0);
         else     rst = ($urandom_range(0, 399) == 0);
      end
      rst = 1'b0; init_req = 1'b0;
      repeat (100) @(posedge clk);
      #3;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
